// File: rtl/counter_thang_nam.sv
// Month/year stage of the century clock: advances month and BCD year from the
// day rollover or manual pulses, and registers leap/days-in-month for the day counter.
module counter_thang_nam (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_auto,
  input  logic        inc_month_manual,
  input  logic        dec_month_manual,
  input  logic        inc_year_manual,
  input  logic        dec_year_manual,
  output logic [3:0]  month,
  output logic [15:0] year_bcd,
  output logic [5:0]  dim,
  output logic        leap,
  output logic        year_carry
);

  logic [3:0]  r_month;
  logic [15:0] r_year_bcd;
  logic [5:0]  r_dim;
  logic        r_leap;
  logic        r_year_carry;

  logic [3:0]  w_month_next;
  logic [15:0] w_year_next;
  logic [16:0] w_year_inc;
  logic [15:0] w_year_dec;
  logic        w_auto_year;
  logic        w_carry_next;
  logic        w_leap_cur;
  logic [5:0]  w_dim_cur;

  // Ripple increment across four BCD digits; bit 16 is the carry out of 9999.
  function automatic logic [16:0] bcd_inc(input logic [15:0] y);
    logic [15:0] r;
    logic        c;
    r = y;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (y[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = y[i*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return {c, r};
  endfunction

  function automatic logic [15:0] bcd_dec(input logic [15:0] y);
    logic [15:0] r;
    logic        b;
    r = y;
    b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (b) begin
        if (y[i*4 +: 4] == 4'd0) begin
          r[i*4 +: 4] = 4'd9;
        end else begin
          r[i*4 +: 4] = y[i*4 +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Divisibility by 4 of a two-digit BCD number: 10*T+O = 2*T + O (mod 4).
  function automatic logic bcd_mod4(input logic [3:0] t, input logic [3:0] o);
    if (!t[0]) return (o == 4'd0) || (o == 4'd4) || (o == 4'd8);
    else       return (o == 4'd2) || (o == 4'd6);
  endfunction

  function automatic logic [5:0] days_of(input logic [3:0] m, input logic lp);
    case (m)
      4'd2:                      return lp ? 6'd29 : 6'd28;
      4'd4, 4'd6, 4'd9, 4'd11:   return 6'd30;
      default:                   return 6'd31;
    endcase
  endfunction

  assign w_year_inc = bcd_inc(r_year_bcd);
  assign w_year_dec = bcd_dec(r_year_bcd);

  always_comb begin
    w_month_next = r_month;
    w_auto_year  = 1'b0;
    if (dec_month_manual) begin
      w_month_next = (r_month == 4'd1) ? 4'd12 : r_month - 4'd1;
    end else if (inc_month_manual) begin
      w_month_next = (r_month == 4'd12) ? 4'd1 : r_month + 4'd1;
    end else if (inc_auto) begin
      w_month_next = (r_month == 4'd12) ? 4'd1 : r_month + 4'd1;
      w_auto_year  = (r_month == 4'd12);
    end
  end

  // Only the auto step may report the century wrap; manual wraps stay silent.
  always_comb begin
    w_year_next  = r_year_bcd;
    w_carry_next = 1'b0;
    if (dec_year_manual) begin
      w_year_next = w_year_dec;
    end else if (inc_year_manual) begin
      w_year_next = w_year_inc[15:0];
    end else if (w_auto_year) begin
      w_year_next  = w_year_inc[15:0];
      w_carry_next = w_year_inc[16];
    end
  end

  always_comb begin
    if (r_year_bcd[7:0] != 8'h00) begin
      w_leap_cur = bcd_mod4(r_year_bcd[7:4], r_year_bcd[3:0]);
    end else begin
      w_leap_cur = bcd_mod4(r_year_bcd[15:12], r_year_bcd[11:8]);
    end
  end

  assign w_dim_cur = days_of(r_month, w_leap_cur);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_month      <= 4'd1;
      r_year_bcd   <= 16'h2000;
      r_year_carry <= 1'b0;
      r_leap       <= 1'b1;
      r_dim        <= 6'd31;
    end else begin
      r_month      <= w_month_next;
      r_year_bcd   <= w_year_next;
      r_year_carry <= w_carry_next;
      r_leap       <= w_leap_cur;
      r_dim        <= w_dim_cur;
    end
  end

  assign month      = r_month;
  assign year_bcd   = r_year_bcd;
  assign dim        = r_dim;
  assign leap       = r_leap;
  assign year_carry = r_year_carry;

endmodule

// File: tb/tb_counter_thang_nam.sv
module tb_counter_thang_nam;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inc_auto = 1'b0;
  logic        inc_month_manual = 1'b0;
  logic        dec_month_manual = 1'b0;
  logic        inc_year_manual = 1'b0;
  logic        dec_year_manual = 1'b0;
  logic [3:0]  month;
  logic [15:0] year_bcd;
  logic [5:0]  dim;
  logic        leap;
  logic        year_carry;

  int n_tests = 0;
  int n_fail  = 0;

  counter_thang_nam dut (
    .clk              (clk),
    .rst              (rst),
    .inc_auto         (inc_auto),
    .inc_month_manual (inc_month_manual),
    .dec_month_manual (dec_month_manual),
    .inc_year_manual  (inc_year_manual),
    .dec_year_manual  (dec_year_manual),
    .month            (month),
    .year_bcd         (year_bcd),
    .dim              (dim),
    .leap             (leap),
    .year_carry       (year_carry)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change at negedge; outputs are sampled 1 time unit after posedge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input int n, input logic ia, input logic im, input logic dm,
                      input logic iy, input logic dy);
    @(negedge clk);
    inc_auto = ia; inc_month_manual = im; dec_month_manual = dm;
    inc_year_manual = iy; dec_year_manual = dy;
    repeat (n) @(posedge clk);
    #1;
    inc_auto = 0; inc_month_manual = 0; dec_month_manual = 0;
    inc_year_manual = 0; dec_year_manual = 0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_month", {12'd0, month}, 16'd1);
    check("rst_year", year_bcd, 16'h2000);
    check("rst_leap", {15'd0, leap}, 16'd1);
    check("rst_dim", {10'd0, dim}, 16'd31);
    check("rst_carry", {15'd0, year_carry}, 16'd0);
    @(negedge clk); rst = 1'b0;

    hold(11, 1, 0, 0, 0, 0);
    check("auto11_month", {12'd0, month}, 16'd12);
    check("auto11_year", year_bcd, 16'h2000);
    tick();
    check("dec_dim", {10'd0, dim}, 16'd31);
    hold(1, 1, 0, 0, 0, 0);
    check("roll_month", {12'd0, month}, 16'd1);
    check("roll_year", year_bcd, 16'h2001);
    check("roll_carry", {15'd0, year_carry}, 16'd0);
    tick();
    check("2001_leap", {15'd0, leap}, 16'd0);
    check("2001_dim", {10'd0, dim}, 16'd31);

    // February across leap-rule years
    hold(1, 0, 0, 0, 0, 1);
    hold(1, 0, 1, 0, 0, 0);
    check("feb_month", {12'd0, month}, 16'd2);
    check("y2000", year_bcd, 16'h2000);
    tick();
    check("dim2000", {10'd0, dim}, 16'd29);
    hold(100, 0, 0, 0, 0, 1);
    check("y1900", year_bcd, 16'h1900);
    tick();
    check("dim1900", {10'd0, dim}, 16'd28);
    check("leap1900", {15'd0, leap}, 16'd0);
    hold(124, 0, 0, 0, 1, 0);
    check("y2024", year_bcd, 16'h2024);
    tick();
    check("dim2024", {10'd0, dim}, 16'd29);
    hold(1, 0, 0, 0, 0, 1);
    check("y2023", year_bcd, 16'h2023);
    tick();
    check("dim2023", {10'd0, dim}, 16'd28);
    hold(77, 0, 0, 0, 1, 0);
    check("y2100", year_bcd, 16'h2100);
    tick();
    check("dim2100", {10'd0, dim}, 16'd28);
    hold(300, 0, 0, 0, 1, 0);
    check("y2400", year_bcd, 16'h2400);
    tick();
    check("dim2400", {10'd0, dim}, 16'd29);

    // Century wrap through the auto step
    hold(7599, 0, 0, 0, 1, 0);
    check("y9999", year_bcd, 16'h9999);
    hold(10, 0, 1, 0, 0, 0);
    check("m12", {12'd0, month}, 16'd12);
    tick();
    check("dim_dec", {10'd0, dim}, 16'd31);
    hold(1, 1, 0, 0, 0, 0);
    check("wrap_month", {12'd0, month}, 16'd1);
    check("wrap_year", year_bcd, 16'h0000);
    check("wrap_carry", {15'd0, year_carry}, 16'd1);
    tick();
    check("wrap_carry_off", {15'd0, year_carry}, 16'd0);
    check("y0000_leap", {15'd0, leap}, 16'd1);
    hold(1, 0, 0, 0, 0, 1);
    check("dec0000_year", year_bcd, 16'h9999);
    check("dec0000_carry", {15'd0, year_carry}, 16'd0);

    // Manual month wraps and simultaneous pulses
    hold(1, 0, 0, 1, 0, 0);
    check("mdec_wrap", {12'd0, month}, 16'd12);
    check("mdec_wrap_year", year_bcd, 16'h9999);
    hold(1, 1, 0, 1, 0, 0);
    check("sim_dec_month", {12'd0, month}, 16'd11);
    check("sim_dec_year", year_bcd, 16'h9999);
    hold(1, 0, 1, 0, 0, 0);
    check("m12b", {12'd0, month}, 16'd12);
    hold(1, 1, 0, 0, 1, 0);
    check("sim_iy_month", {12'd0, month}, 16'd1);
    check("sim_iy_year", year_bcd, 16'h0000);
    check("sim_iy_carry", {15'd0, year_carry}, 16'd0);
    hold(1, 0, 0, 1, 0, 0);
    hold(1, 0, 1, 0, 0, 0);
    check("minc_wrap", {12'd0, month}, 16'd1);
    check("minc_wrap_year", year_bcd, 16'h0000);

    // Mid-operation reset
    hold(2057, 0, 0, 0, 1, 0);
    hold(6, 0, 1, 0, 0, 0);
    check("pre_month", {12'd0, month}, 16'd7);
    check("pre_year", year_bcd, 16'h2057);
    tick();
    check("pre_dim", {10'd0, dim}, 16'd31);
    check("pre_leap", {15'd0, leap}, 16'd0);
    @(negedge clk); rst = 1'b1; inc_auto = 1'b1;
    tick();
    rst = 1'b0; inc_auto = 1'b0;
    check("mrst_month", {12'd0, month}, 16'd1);
    check("mrst_year", year_bcd, 16'h2000);
    check("mrst_dim", {10'd0, dim}, 16'd31);
    check("mrst_leap", {15'd0, leap}, 16'd1);
    check("mrst_carry", {15'd0, year_carry}, 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
